alu_cmp_sequencer: RTL and testbench
====================================

# alu_cmp_sequencer

Control stage directly upstream of the 8-bit ALU comparator. It accepts operand bytes from a valid/ready byte stream, presents them to the comparator as A then B, and pulses the comparator's active-low enable for exactly one evaluation cycle. It then registers the comparator result and flags and holds them on a valid/ready result port. It also keeps saturating activity counters and a sticky protocol-error flag.

## Interface
- WIDTH, 8: operand and result width in bits.
- CNT_W, 16: width of the activity counters.

- clk_in  input  1  rising-edge clock.
- rst_n_in  input  1  reset; synchronous, active-low.
- clear_in  input  1  synchronous abort of the operation in progress; active-high.
- data_in  input  WIDTH  operand byte; the first accepted byte is A, the second is B.
- data_valid_in  input  1  data_in is valid.
- data_ready_out  output  1  the block can accept a byte this cycle.
- a_reg_out  output  WIDTH  operand A, driven to the comparator.
- b_reg_out  output  WIDTH  operand B, driven to the comparator.
- en_out  output  1  comparator enable, active-low (0 = evaluate).
- y_in  input  WIDTH  comparator result code.
- carry_in  input  1  comparator carry flag.
- zero_in  input  1  comparator zero flag.
- res_out  output  WIDTH  registered result code.
- carry_out  output  1  registered carry flag.
- zero_out  output  1  registered zero flag.
- res_valid_out  output  1  result is valid and held.
- res_ready_in  input  1  consumer accepts the result.
- cmp_cnt_out  output  CNT_W  number of evaluations performed; saturating.
- eq_cnt_out  output  CNT_W  number of evaluations with zero_in=1; saturating.
- err_out  output  1  sticky flag: an illegal result code was sampled.

## Operation
- The FSM has four states: LOAD_A, LOAD_B, EVAL, HOLD.
- A transfer occurs on any cycle with data_valid_in & data_ready_out.
- data_ready_out is decoded from state: it is 1 only in LOAD_A and LOAD_B.
- LOAD_A: a transfer writes a_reg_out and moves to LOAD_B.
- LOAD_B: a transfer writes b_reg_out and moves to EVAL.
- EVAL: en_out=0 for this cycle only. The comparator is combinational, so the block samples y_in, carry_in and zero_in at the closing edge of EVAL into res_out, carry_out and zero_out. The same edge sets res_valid_out and moves to HOLD.
- HOLD: res_out, carry_out and zero_out stay stable while res_valid_out=1. On res_valid_out & res_ready_in, res_valid_out clears and the FSM moves to LOAD_A.
- en_out=1 in every state except EVAL.
- a_reg_out and b_reg_out hold their values until overwritten by a new transfer.
- Legal result codes are 0x01 (A<B), 0x80 (A>B) and 0x00 (A==B, which requires zero_in=1).
- Sampling any other code, or 0x00 with zero_in=0, sets err_out. err_out stays set until reset.
- cmp_cnt_out increments at every EVAL edge. eq_cnt_out increments at an EVAL edge when zero_in=1. Both counters stop at all-ones; there is no wrap-around.
- clear_in (any state) forces the FSM to LOAD_A on the next edge, clears res_valid_out and forces en_out=1. It does not change the operand registers, the counters or err_out.
- clear_in takes priority over a same-cycle transfer: the byte is not captured.
- clear_in asserted during EVAL: nothing is sampled and the counters do not increment.
- Reset values: state LOAD_A; a_reg_out, b_reg_out, res_out=0; carry_out, zero_out, res_valid_out, err_out=0; both counters 0; en_out=1; data_ready_out=1.
- Reset has priority over clear_in. A reset asserted mid-operation abandons the operation with no output pulse.

## Timing
- If A is accepted at edge N and B at edge N+1, en_out is 0 during cycle N+1→N+2 only. res_valid_out rises at edge N+2.
- Minimum of 4 cycles per comparison when res_ready_in is held high; the LOAD_A transfer follows in the cycle after the result handshake.
- Gaps in data_valid_in stretch LOAD_A or LOAD_B by whole cycles, with no side effects.
- data_ready_out=0 throughout EVAL and HOLD, so a new operand cannot overlap a pending result.
- All outputs are registered, except data_ready_out and en_out, which are decoded from the registered state (glitch-free, no combinational input→output path).

## Structure
- Shared package alu_pkg holds:
  - the state enum {LOAD_A, LOAD_B, EVAL, HOLD};
  - the result-code constants CMP_LT=8'h01, CMP_GT=8'h80, CMP_EQ=8'h00;
  - the default WIDTH.
- One sub-module, sat_counter (parameter CNT_W; inputs inc and a synchronous active-low reset; output count), is instantiated twice.
- The FSM, operand registers, result registers and error check live in the top level.

## Test plan
- Reset: hold rst_n_in=0 for 2 edges → en_out=1, data_ready_out=1, res_valid_out=0, both counters 0, err_out=0.
- A=0x05 at edge N, B=0x09 at edge N+1, res_ready_in=1 → en_out=0 for exactly one cycle; at edge N+2, res_out=0x01, zero_out=0, res_valid_out=1 for one cycle; cmp_cnt_out=1.
- A=0x3C, B=0x3C → res_out=0x00, zero_out=1, eq_cnt_out increments by 1, err_out stays 0. Then A=0xF0, B=0x0F → res_out=0x80.
- Hold res_ready_in=0 for 5 cycles after a result → res_out stable, data_ready_out=0, en_out=1. Raise res_ready_in → data_ready_out=1 on the next cycle.
- clear_in pulsed after A=0x11 is accepted → the next byte 0x22 is captured as A. clear_in coincident with a transfer → byte dropped, still in LOAD_A.
- Comparator stub returns y_in=0x42 → err_out=1 and remains 1 through subsequent legal comparisons until reset.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared states, comparator result codes and default width for the ALU comparator front end.
package alu_pkg;
  localparam int DEF_WIDTH = 8;
  localparam logic [7:0] CMP_LT = 8'h01;
  localparam logic [7:0] CMP_GT = 8'h80;
  localparam logic [7:0] CMP_EQ = 8'h00;
  typedef enum logic [1:0] {LOAD_A, LOAD_B, EVAL, HOLD} state_e;
endpackage

// File: rtl/alu_cmp_sequencer_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_q, count_d;
  always_comb count_d = (inc && count_q != '1) ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk_in) count_q <= !rst_n_in ? '0 : count_d;
  assign count = count_q;
endmodule

// File: rtl/alu_cmp_sequencer.sv
// alu_cmp_sequencer: loads A/B from a byte stream, strobes the comparator for one cycle
// and holds its registered result on a valid/ready port, with activity counters and an error flag.
module alu_cmp_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             clear_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid_in,
  output logic             data_ready_out,
  output logic [WIDTH-1:0] a_reg_out,
  output logic [WIDTH-1:0] b_reg_out,
  output logic             en_out,
  input  logic [WIDTH-1:0] y_in,
  input  logic             carry_in,
  input  logic             zero_in,
  output logic [WIDTH-1:0] res_out,
  output logic             carry_out,
  output logic             zero_out,
  output logic             res_valid_out,
  input  logic             res_ready_in,
  output logic [CNT_W-1:0] cmp_cnt_out,
  output logic [CNT_W-1:0] eq_cnt_out,
  output logic             err_out
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             carry_q, carry_d, zero_q, zero_d, valid_q, valid_d, err_q, err_d;
  logic             xfer, eval_fire, illegal;
  assign data_ready_out = state_q == LOAD_A || state_q == LOAD_B;
  assign en_out         = state_q != EVAL;
  assign xfer           = data_valid_in && data_ready_out;
  assign eval_fire      = state_q == EVAL && !clear_in;
  // 0x00 is only a legal code when the comparator also reports zero
  assign illegal = !(y_in == WIDTH'(CMP_LT) || y_in == WIDTH'(CMP_GT) ||
                     (y_in == WIDTH'(CMP_EQ) && zero_in));
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (clear_in) begin
      state_d = LOAD_A;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        LOAD_A: if (xfer) begin
          a_d     = data_in;
          state_d = LOAD_B;
        end
        LOAD_B: if (xfer) begin
          b_d     = data_in;
          state_d = EVAL;
        end
        EVAL: begin
          res_d   = y_in;
          carry_d = carry_in;
          zero_d  = zero_in;
          valid_d = 1'b1;
          err_d   = err_q || illegal;
          state_d = HOLD;
        end
        default: if (res_ready_in) begin
          valid_d = 1'b0;
          state_d = LOAD_A;
        end
      endcase
    end
  end
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q <= LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end
  sat_counter #(.CNT_W(CNT_W)) u_cmp_cnt (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .inc     (eval_fire),
    .count   (cmp_cnt_out)
  );
  sat_counter #(.CNT_W(CNT_W)) u_eq_cnt (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .inc     (eval_fire && zero_in),
    .count   (eq_cnt_out)
  );
  assign a_reg_out     = a_q;
  assign b_reg_out     = b_q;
  assign res_out       = res_q;
  assign carry_out     = carry_q;
  assign zero_out      = zero_q;
  assign res_valid_out = valid_q;
  assign err_out       = err_q;
endmodule

// File: tb/tb_alu_cmp_sequencer.sv
// tb_alu_cmp_sequencer: random compare transactions scored against a transaction-level model.
module tb_alu_cmp_sequencer;
  localparam int W = 8;
  localparam int CW = 4;
  localparam logic [CW-1:0] CMAX = '1;
  logic clk = 1'b0, rst_n_in = 1'b0, clear_in = 1'b0, data_valid_in = 1'b0, res_ready_in = 1'b1;
  logic [W-1:0] data_in = '0, y_in, a_reg_out, b_reg_out, res_out;
  logic data_ready_out, en_out, carry_in, zero_in, carry_out, zero_out, res_valid_out, err_out;
  logic [CW-1:0] cmp_cnt_out, eq_cnt_out;
  logic stub_bad = 1'b0;
  logic [W-1:0] stub_code = 8'h42;
  int n_chk = 0, n_fail = 0;
  logic [CW-1:0] exp_cmp = '0, exp_eq = '0;
  logic exp_err = 1'b0;
  logic [W-1:0] exp_a = '0;
  alu_cmp_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk_in(clk), .rst_n_in(rst_n_in), .clear_in(clear_in), .data_in(data_in),
    .data_valid_in(data_valid_in), .data_ready_out(data_ready_out), .a_reg_out(a_reg_out),
    .b_reg_out(b_reg_out), .en_out(en_out), .y_in(y_in), .carry_in(carry_in), .zero_in(zero_in),
    .res_out(res_out), .carry_out(carry_out), .zero_out(zero_out), .res_valid_out(res_valid_out),
    .res_ready_in(res_ready_in), .cmp_cnt_out(cmp_cnt_out), .eq_cnt_out(eq_cnt_out), .err_out(err_out)
  );
  always #5 clk = ~clk;
  // comparator stub: behaves like the real comparator unless told to emit a bad code
  always_comb begin
    y_in     = a_reg_out < b_reg_out ? 8'h01 : a_reg_out > b_reg_out ? 8'h80 : 8'h00;
    carry_in = a_reg_out < b_reg_out;
    zero_in  = a_reg_out == b_reg_out;
    if (stub_bad) begin
      y_in     = stub_code;
      carry_in = 1'b0;
      zero_in  = 1'b0;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return v == CMAX ? v : v + 1'b1;
  endfunction
  task automatic do_reset();
    rst_n_in = 1'b0; clear_in = 1'b0; data_valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n_in = 1'b1;
    exp_cmp = '0; exp_eq = '0; exp_err = 1'b0; exp_a = '0;
    check("rst_en", en_out, 1);
    check("rst_ready", data_ready_out, 1);
    check("rst_valid", res_valid_out, 0);
    check("rst_cmp_cnt", cmp_cnt_out, 0);
    check("rst_eq_cnt", eq_cnt_out, 0);
    check("rst_err", err_out, 0);
    check("rst_a", a_reg_out, 0);
    check("rst_res", res_out, 0);
  endtask
  task automatic send(input logic [W-1:0] v);
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap) @(posedge clk);
    #1 data_in = v; data_valid_in = 1'b1;
    for (int i = 0; i < 20 && !data_ready_out; i++) @(negedge clk);
    if (!data_ready_out) begin
      check("ready_timeout", 0, 1);
      data_valid_in = 1'b0;
      return;
    end
    @(posedge clk);
    #1 data_valid_in = 1'b0; data_in = $urandom;
  endtask
  task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input logic bad, input int hold);
    logic [W-1:0] ey;
    logic ez, ec;
    stub_bad = bad;
    res_ready_in = hold == 0;
    ey = bad ? stub_code : a < b ? 8'h01 : a > b ? 8'h80 : 8'h00;
    ez = !bad && a == b;
    ec = !bad && a < b;
    send(a);
    exp_a = a;
    send(b);
    check("eval_en_low", en_out, 0);
    check("eval_not_ready", data_ready_out, 0);
    @(posedge clk); #1;
    exp_cmp = sat_inc(exp_cmp);
    if (ez) exp_eq = sat_inc(exp_eq);
    exp_err = exp_err | bad;
    check("hold_en", en_out, 1);
    check("res_valid", res_valid_out, 1);
    check("res_code", res_out, ey);
    check("res_zero", zero_out, ez);
    check("res_carry", carry_out, ec);
    check("cmp_cnt", cmp_cnt_out, exp_cmp);
    check("eq_cnt", eq_cnt_out, exp_eq);
    check("err", err_out, exp_err);
    check("a_reg", a_reg_out, a);
    check("b_reg", b_reg_out, b);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("stall_valid", res_valid_out, 1);
      check("stall_res", res_out, ey);
      check("stall_ready", data_ready_out, 0);
      check("stall_en", en_out, 1);
    end
    res_ready_in = 1'b1;
    @(posedge clk); #1;
    check("post_valid", res_valid_out, 0);
    check("post_ready", data_ready_out, 1);
    stub_bad = 1'b0;
  endtask
  initial begin
    do_reset();
    run_cmp(8'h05, 8'h09, 0, 0);
    run_cmp(8'h3C, 8'h3C, 0, 0);
    run_cmp(8'hF0, 8'h0F, 0, 0);
    run_cmp(8'hA5, 8'h5A, 0, 5);
    // clear after A: the next byte must become A again
    send(8'h11);
    clear_in = 1'b1;
    @(posedge clk); #1 clear_in = 1'b0;
    check("clr_ready", data_ready_out, 1);
    check("clr_a_kept", a_reg_out, 8'h11);
    run_cmp(8'h22, 8'h33, 0, 0);
    // clear coincident with a transfer drops the byte
    data_in = 8'h77; data_valid_in = 1'b1; clear_in = 1'b1;
    @(posedge clk); #1 data_valid_in = 1'b0; clear_in = 1'b0;
    check("clr_drop_a", a_reg_out, 8'h22);
    check("clr_drop_ready", data_ready_out, 1);
    run_cmp(8'h90, 8'h10, 0, 0);
    // clear during EVAL: no sample, no count
    send(8'h01); send(8'h01);
    check("clr_eval_en", en_out, 0);
    clear_in = 1'b1;
    @(posedge clk); #1 clear_in = 1'b0;
    check("clr_eval_valid", res_valid_out, 0);
    check("clr_eval_cnt", cmp_cnt_out, exp_cmp);
    check("clr_eval_eq", eq_cnt_out, exp_eq);
    check("clr_eval_ready", data_ready_out, 1);
    run_cmp(8'h42, 8'h00, 1, 0);
    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
      run_cmp(a, b, 0, $urandom_range(0, 2));
    end
    check("cmp_sat", cmp_cnt_out, CMAX);
    // reset mid-operation abandons it and clears the sticky error
    send(8'h55);
    do_reset();
    stub_code = 8'h00;
    run_cmp(8'h12, 8'h34, 1, 0);
    run_cmp(8'h07, 8'h07, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
